// File: rtl/spi_host_frame_tx.sv
// Host-side SPI frame transmitter: address byte plus 1..MAX_BYTES data bytes, LSB first, with readback capture.
// Optional feature macro SPI_HOST_WRITE_VERIFY_EN: re-read each write frame and flag mismatches on verify_err.
module spi_host_frame_tx #(
    parameter int MAX_BYTES = 8,
    parameter int IDLE_GAP  = 4,
    parameter int RD_LAT    = 1,
    localparam int LW       = $clog2(MAX_BYTES + 1)
) (
    input  logic          sclk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          cmd_rd,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          serial_out,
    input  logic          serial_in,
    output logic          sclk_en,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          verify_err
);
    localparam int WW = $clog2(IDLE_GAP + RD_LAT + 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_TAIL, S_GAP} state_t;
    state_t state, state_nxt;

    logic [2:0]    bit_cnt;
    logic [LW-1:0] byte_cnt, len_q;
    logic [7:0]    addr_q, tx_sh, rx_sh;
    logic          rd_q, aborted;
    logic [WW-1:0] wait_cnt;
    logic          len_ok, start, byte_end, last_byte, boundary, underrun, load;
    logic          tail_last, gap_last, verify_pending;
    logic          drv_bit, drv_last, samp_en, samp_last;

    assign len_ok    = (cmd_len != '0) && (cmd_len <= MAX_LEN);
    assign byte_end  = (state == S_ADDR || state == S_DATA) && (bit_cnt == 3'd7);
    assign last_byte = (state == S_DATA) && (byte_cnt == len_q - LW'(1));
    // A byte boundary is the last bit cycle of any byte that has a successor.
    assign boundary  = byte_end && !last_byte;
    assign underrun  = boundary && !rd_q && !wr_valid;
    assign load      = boundary && !rd_q && wr_valid;
    assign tail_last = (wait_cnt == WW'(RD_LAT - 1));
    assign gap_last  = (wait_cnt == WW'(IDLE_GAP - 1));
    assign start     = (state == S_IDLE && cmd_valid && len_ok) ||
                       (state == S_GAP && gap_last && verify_pending);
    assign drv_bit   = (state == S_DATA);
    assign drv_last  = drv_bit && (bit_cnt == 3'd7);
    assign serial_out = tx_sh[0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cmd_valid && len_ok) state_nxt = S_ADDR;
            S_ADDR: if (byte_end) state_nxt = underrun ? S_GAP : S_DATA;
            S_DATA: if (byte_end) begin
                if (last_byte)     state_nxt = (RD_LAT == 0) ? S_GAP : S_TAIL;
                else if (underrun) state_nxt = S_GAP;
            end
            S_TAIL: if (tail_last) state_nxt = S_GAP;
            S_GAP:  if (gap_last) state_nxt = verify_pending ? S_ADDR : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        sclk_en   = 1'b0;
        wr_ready  = 1'b0;
        err       = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                err       = cmd_valid && !len_ok;
            end
            S_ADDR, S_DATA: begin
                sclk_en  = 1'b1;
                wr_ready = load;
                err      = underrun;
            end
            S_TAIL: sclk_en = 1'b1;
            S_GAP:  done = (wait_cnt == '0) && !aborted && !verify_pending;
            default: ;
        endcase
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            aborted  <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            wait_cnt <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (start) begin
                if (state == S_IDLE) begin
                    addr_q <= cmd_addr;
                    len_q  <= cmd_len;
                    rd_q   <= cmd_rd;
                    tx_sh  <= cmd_addr;
                end else begin
                    rd_q  <= 1'b1;
                    tx_sh <= addr_q;
                end
                bit_cnt  <= '0;
                byte_cnt <= '0;
                aborted  <= 1'b0;
            end else if (state == S_ADDR || state == S_DATA) begin
                bit_cnt <= bit_cnt + 3'd1;
                // Read data, underrun and the tail all drive zeros after the last shifted bit.
                if (load)           tx_sh <= wr_data;
                else if (byte_end)  tx_sh <= '0;
                else                tx_sh <= tx_sh >> 1;
                if (drv_last) byte_cnt <= byte_cnt + LW'(1);
                if (underrun) aborted <= 1'b1;
            end

            if (state_nxt != state)                   wait_cnt <= '0;
            else if (state == S_TAIL || state == S_GAP) wait_cnt <= wait_cnt + WW'(1);

            if (samp_en) rx_sh <= {serial_in, rx_sh[7:1]};
            if (samp_last) begin
                rd_data  <= {serial_in, rx_sh[7:1]};
                rd_valid <= 1'b1;
            end
        end
    end

    // Readback of a data bit arrives RD_LAT cycles after it is driven.
    generate
        if (RD_LAT == 0) begin : g_no_lat
            assign samp_en   = drv_bit;
            assign samp_last = drv_last;
        end else begin : g_lat
            logic [RD_LAT-1:0] en_pipe, last_pipe;
            always_ff @(posedge sclk or negedge rstn) begin
                if (!rstn) begin
                    en_pipe   <= '0;
                    last_pipe <= '0;
                end else begin
                    en_pipe[0]   <= drv_bit;
                    last_pipe[0] <= drv_last;
                    for (int i = 1; i < RD_LAT; i++) begin
                        en_pipe[i]   <= en_pipe[i-1];
                        last_pipe[i] <= last_pipe[i-1];
                    end
                end
            end
            assign samp_en   = en_pipe[RD_LAT-1];
            assign samp_last = last_pipe[RD_LAT-1];
        end
    endgenerate

`ifdef SPI_HOST_WRITE_VERIFY_EN
    localparam int AW = $clog2(MAX_BYTES);
    logic [7:0]    wbuf [MAX_BYTES];
    logic [AW-1:0] w_idx, rx_idx;
    logic          vfy_q, mism;

    assign w_idx          = (state == S_ADDR) ? '0 : byte_cnt[AW-1:0] + AW'(1);
    assign verify_pending = !rd_q && !aborted;
    assign verify_err     = done && mism;

    // NOTE: the write buffer has no reset; entries are always written before the verify frame reads them.
    always_ff @(posedge sclk) begin
        if (load) wbuf[w_idx] <= wr_data;
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            rx_idx <= '0;
            vfy_q  <= 1'b0;
            mism   <= 1'b0;
        end else if (start) begin
            rx_idx <= '0;
            vfy_q  <= (state == S_GAP);
            mism   <= 1'b0;
        end else if (samp_last) begin
            rx_idx <= rx_idx + AW'(1);
            if (vfy_q && ({serial_in, rx_sh[7:1]} != wbuf[rx_idx])) mism <= 1'b1;
        end
    end
`else
    assign verify_pending = 1'b0;
    assign verify_err     = 1'b0;
`endif

endmodule
